// File: rtl/receiver.sv
// receiver: serial byte receiver, one clock per bit, LSB first.
// Define RX_STOP_BIT_EN to require a high stop bit after the data bits.
module receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 en,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

`ifdef RX_STOP_BIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
  } state_t;
`endif

  // Power-up values match the reset values so outputs are never X.
  state_t               state_q = IDLE;
  logic [CW-1:0]        cnt_q   = '0;
  logic [DATA_BITS-1:0] shreg_q = '0;
  logic [DATA_BITS-1:0] data_q  = '0;
  logic                 rdy_q   = 1'b0;

  state_t               state_d;
  logic [CW-1:0]        cnt_d;
  logic [DATA_BITS-1:0] shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 rdy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!x) begin
            state_d = DATA;
            cnt_d   = '0;
            shreg_d = '0;
            rdy_d   = 1'b0;
          end
        end
        DATA: begin
          shreg_d[cnt_q] = x;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef RX_STOP_BIT_EN
            state_d = STOP;
`else
            state_d = IDLE;
            data_d  = shreg_d;
            rdy_d   = 1'b1;
`endif
          end
        end
`ifdef RX_STOP_BIT_EN
        // A low stop bit drops the byte and is not a new start bit.
        STOP: begin
          state_d = IDLE;
          if (x) begin
            data_d = shreg_q;
            rdy_d  = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy  = rdy_q;
  assign data = data_q;

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: scoreboard bench for receiver with randomized frames,
// enable drops, mid-frame reset and idle gaps.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       x   = 1'b1;
  logic       en  = 1'b0;
  logic       rdy;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       rdy_p  = 1'b0;
  logic [7:0] data_p = 8'h00;

  receiver #(.DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .en  (en),
    .rdy (rdy),
    .data(data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each byte completion must match the oldest outstanding frame;
  // otherwise data must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdy === 1'b1 && rdy_p !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rdy: got data %h expected no byte",
                   data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL byte: got %h expected %h", data, e);
          end
        end
      end else begin
        checks++;
        if (data !== data_p || $isunknown(rdy)) begin
          errors++;
          $display("FAIL data_hold: got %h/%b expected %h", data, rdy,
                   data_p);
        end
      end
    end
    rdy_p  = rdy;
    data_p = data;
  end

  task automatic drive(input logic xv, input logic ev);
    x  = xv;
    en = ev;
    @(posedge clk);
    #1;
  endtask

  // abort_at >= 0 drops en instead of sending that data bit.
  task automatic send_frame(input logic [7:0] b, input int abort_at,
                            input bit chk_rdy);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        drive(1'($urandom_range(1)), 1'b0);
        return;
      end
`ifndef RX_STOP_BIT_EN
      if (i == 7) exp_q.push_back(b);
`endif
      drive(b[i], 1'b1);
`ifndef RX_STOP_BIT_EN
      if (chk_rdy && i < 7) chk("rdy_during_frame", 8'(rdy), 8'h00);
`else
      if (chk_rdy) chk("rdy_during_frame", 8'(rdy), 8'h00);
`endif
    end
`ifdef RX_STOP_BIT_EN
    exp_q.push_back(b);
    drive(1'b1, 1'b1);
`endif
  endtask

  initial begin
    logic [7:0] b;
    #1;
    chk("powerup_data", data, 8'h00);
    chk("powerup_rdy", 8'(rdy), 8'h00);
    checks++;
    if ($isunknown({rdy, data})) begin
      errors++;
      $display("FAIL powerup_xz: got %b%h expected no X/Z", rdy, data);
    end

    for (int i = 0; i < 40; i++) drive(1'(i % 2), 1'b0);
    chk("en0_data", data, 8'h00);
    chk("en0_rdy", 8'(rdy), 8'h00);

    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    chk("idle_data", data, 8'h00);
    chk("idle_rdy", 8'(rdy), 8'h00);
    drive(1'b0, 1'b1);
    chk("start_rdy", 8'(rdy), 8'h00);
    drive(1'b1, 1'b0);

    b = 8'b00011100;
    send_frame(b, -1, 1'b1);
    chk("frame_rdy", 8'(rdy), 8'h01);
    chk("frame_data", data, 8'b00011100);
`ifndef RX_STOP_BIT_EN
    drive(1'b0, 1'b1);
    chk("nostop_rdy", 8'(rdy), 8'h00);
    chk("nostop_data", data, 8'b00011100);
    drive(1'b1, 1'b0);
`endif

    drive(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'($urandom_range(1)), 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_rdy", 8'(rdy), 8'h00);
    x = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_data", data, 8'h00);
    b = 8'hA5;
    send_frame(b, -1, 1'b1);
    chk("a5_rdy", 8'(rdy), 8'h01);
    chk("a5_data", data, 8'hA5);

    for (int f = 0; f < 60; f++) begin
      int gap;
      int ab;
      b   = 8'($urandom);
      gap = int'($urandom_range(3));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(3) == 0) drive(1'($urandom_range(1)), 1'b0);
        else drive(1'b1, 1'b1);
      end
      ab = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
      send_frame(b, ab, 1'b0);
      if (ab >= 0) chk("abort_rdy", 8'(rdy), 8'h00);
    end

    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    chk("queue_empty", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
